// File: rtl/mc_cfg_pkg.sv
// mc_cfg_pkg
// Shared types and constants for the memory-controller configuration master:
// table entry layout, AHB encodings, FSM state type, default CSR map and the
// default configuration table loaded into mc_cfg_rom.
package mc_cfg_pkg;

    // Physical depth of a configuration table; NUM_ENTRIES must not exceed this.
    localparam int unsigned CFG_TABLE_DEPTH = 32;
    localparam int unsigned CFG_TABLE_IDX_W = $clog2(CFG_TABLE_DEPTH);

    // AHB encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Default memory-controller CSR map
    localparam logic [31:0] CSR_BASE      = 32'h4000_0000;
    localparam logic [31:0] CSR_INIT_CTRL = CSR_BASE + 32'h00;  // bit 0: init request
    localparam logic [31:0] CSR_STATUS    = CSR_BASE + 32'h04;  // bit 0: initialize_done
    localparam logic [31:0] CSR_TIMING0   = CSR_BASE + 32'h10;  // tRCD / tRP / tCL
    localparam logic [31:0] CSR_TIMING1   = CSR_BASE + 32'h14;  // tRAS / tRC
    localparam logic [31:0] CSR_TIMING2   = CSR_BASE + 32'h18;  // refresh interval

    localparam logic [31:0] TIMING0_VAL   = 32'h0006_0606;
    localparam logic [31:0] TIMING1_VAL   = 32'h0000_1422;
    localparam logic [31:0] TIMING2_VAL   = 32'h0000_0C30;
    localparam logic [31:0] INIT_REQ_BIT  = 32'h0000_0001;
    localparam logic [31:0] INIT_DONE_BIT = 32'h0000_0001;

    typedef enum logic [1:0] {
        OpWrite = 2'd0,
        OpPoll  = 2'd1,
        OpWait  = 2'd2,
        OpEnd   = 2'd3
    } cfg_op_e;

    typedef struct packed {
        cfg_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } cfg_entry_t;

    typedef cfg_entry_t [CFG_TABLE_DEPTH-1:0] cfg_table_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StGrant,
        StAddr,
        StData,
        StDelay,
        StDone,
        StErr
    } cfg_state_e;

    function automatic cfg_entry_t cfg_entry(cfg_op_e op, logic [31:0] addr,
                                             logic [31:0] data, logic [31:0] mask);
        cfg_entry_t e;
        e.op   = op;
        e.addr = addr;
        e.data = data;
        e.mask = mask;
        return e;
    endfunction

    // Timing fields, init request, wait for initialize_done, end.
    function automatic cfg_table_t cfg_default_table();
        cfg_table_t t;
        for (int i = 0; i < int'(CFG_TABLE_DEPTH); i++) begin
            t[i] = cfg_entry(OpEnd, 32'h0, 32'h0, 32'h0);
        end
        t[0] = cfg_entry(OpWrite, CSR_TIMING0, TIMING0_VAL, 32'h0);
        t[1] = cfg_entry(OpWrite, CSR_TIMING1, TIMING1_VAL, 32'h0);
        t[2] = cfg_entry(OpWrite, CSR_TIMING2, TIMING2_VAL, 32'h0);
        t[3] = cfg_entry(OpWrite, CSR_INIT_CTRL, INIT_REQ_BIT, 32'h0);
        t[4] = cfg_entry(OpPoll, CSR_STATUS, INIT_DONE_BIT, INIT_DONE_BIT);
        t[5] = cfg_entry(OpEnd, 32'h0, 32'h0, 32'h0);
        return t;
    endfunction

    localparam cfg_table_t CFG_DEFAULT_TABLE = cfg_default_table();

endpackage

// File: rtl/mc_cfg_rom.sv
// mc_cfg_rom
// Registered configuration ROM: one entry per cycle, addressed by entry index.
// Ports:
//   clk      in   clock
//   i_idx    in   entry index (IDX_W bits)
//   o_entry  out  registered table entry for the index presented last cycle
module mc_cfg_rom
    import mc_cfg_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter cfg_table_t  CFG_TABLE   = CFG_DEFAULT_TABLE,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_idx,
    output cfg_entry_t       o_entry
);

    logic [CFG_TABLE_IDX_W-1:0] w_tbl_idx;
    cfg_entry_t                 r_entry;

    assign w_tbl_idx = CFG_TABLE_IDX_W'(i_idx);

    always_ff @(posedge clk) begin
        r_entry <= CFG_TABLE[w_tbl_idx];
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/mc_ahb_cfg_master.sv
// mc_ahb_cfg_master
// AHB master that walks a configuration table after reset: register writes,
// read-polls until a masked field matches, and fixed delays. Reports done/error.
// Optional feature: define MC_CFG_POLL_TIMEOUT_EN to bound each POLL entry to
// POLL_TIMEOUT cycles spent in ADDR/DATA (otherwise a poll retries forever).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_start                    start pulse (honoured only in IDLE/DONE/ERR)
//   o_busy/o_done/o_err        status; done/err held until the next start
//   o_err_idx                  index of the entry that failed
//   o_ahb_*                    AHB master outputs (single word transfers)
//   i_ahb_hready/hrdata/hresp  AHB slave response
//   i_ahb_hgrant               arbiter grant
module mc_ahb_cfg_master
    import mc_cfg_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES  = 32,
    parameter int unsigned POLL_TIMEOUT = 4096,
    parameter cfg_table_t  CFG_TABLE    = CFG_DEFAULT_TABLE,
    parameter int unsigned IDX_W        = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [IDX_W-1:0] o_err_idx,
    output logic [31:0]      o_ahb_haddr,
    output logic             o_ahb_hwrite,
    output logic [31:0]      o_ahb_hwdata,
    output logic [1:0]       o_ahb_htrans,
    output logic [2:0]       o_ahb_hsize,
    output logic [2:0]       o_ahb_hburst,
    output logic             o_ahb_hbusreq,
    output logic             o_ahb_hreadyin,
    input  logic             i_ahb_hready,
    input  logic [31:0]      i_ahb_hrdata,
    input  logic [1:0]       i_ahb_hresp,
    input  logic             i_ahb_hgrant
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    cfg_state_e       r_state, w_state_d;
    logic [IDX_W-1:0] r_idx, w_idx_d;
    logic [15:0]      r_cnt, w_cnt_d;
    logic [IDX_W-1:0] r_err_idx, w_err_idx_d;
    cfg_entry_t       w_entry;
    logic             w_advance;
    logic             w_poll_match;
    logic             w_poll_expired;

    // The ROM is addressed with the next index so the entry is already valid
    // in the FETCH cycle that follows an index update.
    mc_cfg_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .CFG_TABLE   (CFG_TABLE),
        .IDX_W       (IDX_W)
    ) u_rom (
        .clk     (clk),
        .i_idx   (w_idx_d),
        .o_entry (w_entry)
    );

    assign w_poll_match = ((i_ahb_hrdata & w_entry.mask) == (w_entry.data & w_entry.mask));

`ifdef MC_CFG_POLL_TIMEOUT_EN
    logic [15:0] r_poll_cnt, w_poll_cnt_d;

    always_comb begin
        w_poll_cnt_d = r_poll_cnt;
        if (r_state == StFetch) begin
            w_poll_cnt_d = '0;
        end else if ((r_state == StAddr || r_state == StData) && (w_entry.op == OpPoll) &&
                     (r_poll_cnt != 16'hFFFF)) begin
            w_poll_cnt_d = r_poll_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= w_poll_cnt_d;
        end
    end

    // Counts the current cycle too; only acted on when a data phase completes,
    // so an issued transfer always finishes before the entry is abandoned.
    assign w_poll_expired = (w_entry.op == OpPoll) &&
                            ((32'(r_poll_cnt) + 32'd1) >= POLL_TIMEOUT);
`else
    // POLL_TIMEOUT only matters when the timeout is built in.
    logic w_unused_poll_timeout;
    assign w_unused_poll_timeout = ^POLL_TIMEOUT;
    assign w_poll_expired        = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_cnt_d     = r_cnt;
        w_err_idx_d = r_err_idx;
        w_advance   = 1'b0;

        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (i_start) begin
                    w_state_d = StFetch;
                    w_idx_d   = '0;
                end
            end
            StFetch: begin
                case (w_entry.op)
                    OpWrite, OpPoll: w_state_d = StGrant;
                    OpWait: begin
                        w_state_d = StDelay;
                        w_cnt_d   = w_entry.data[15:0];
                    end
                    default: w_state_d = StDone;
                endcase
            end
            StGrant: begin
                if (i_ahb_hgrant) begin
                    w_state_d = StAddr;
                end
            end
            StAddr: begin
                if (i_ahb_hready) begin
                    w_state_d = StData;
                end
            end
            StData: begin
                if (i_ahb_hready) begin
                    if ((i_ahb_hresp != HRESP_OKAY) || w_poll_expired) begin
                        w_state_d   = StErr;
                        w_err_idx_d = r_idx;
                    end else if ((w_entry.op == OpWrite) || w_poll_match) begin
                        w_advance = 1'b1;
                    end else begin
                        // Re-issue the poll read; bus request stays asserted.
                        w_state_d = StAddr;
                    end
                end
            end
            StDelay: begin
                if (r_cnt == 16'd0) begin
                    w_advance = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 16'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Running off the end of the table without an END entry also completes.
        if (w_advance) begin
            if (r_idx == IDX_LAST) begin
                w_state_d = StDone;
            end else begin
                w_idx_d   = r_idx + IDX_W'(1);
                w_state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_err_idx <= '0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_cnt     <= w_cnt_d;
            r_err_idx <= w_err_idx_d;
        end
    end

    // Bus outputs decode registered state and the registered ROM entry only.
    always_comb begin
        o_ahb_htrans = HTRANS_IDLE;
        o_ahb_haddr  = '0;
        o_ahb_hwrite = 1'b0;
        o_ahb_hwdata = '0;
        if (r_state == StAddr || r_state == StData) begin
            o_ahb_haddr  = w_entry.addr;
            o_ahb_hwrite = (w_entry.op == OpWrite);
        end
        if (r_state == StAddr) begin
            o_ahb_htrans = HTRANS_NONSEQ;
        end
        if (r_state == StData && w_entry.op == OpWrite) begin
            o_ahb_hwdata = w_entry.data;
        end
    end

    assign o_ahb_hsize    = HSIZE_WORD;
    assign o_ahb_hburst   = HBURST_SINGLE;
    assign o_ahb_hbusreq  = (r_state == StGrant) || (r_state == StAddr) || (r_state == StData);
    assign o_ahb_hreadyin = i_ahb_hready;

    assign o_busy    = (r_state != StIdle) && (r_state != StDone) && (r_state != StErr);
    assign o_done    = (r_state == StDone);
    assign o_err     = (r_state == StErr);
    assign o_err_idx = r_err_idx;

endmodule

// File: tb/tb_mc_ahb_cfg_master.sv
// Directed bench for mc_ahb_cfg_master. DUT A runs three WRITEs then END;
// DUT B runs a POLL followed by a WAIT and completes through index wrap.
module tb_mc_ahb_cfg_master;
    import mc_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr [3] = '{32'h4000_0010, 32'h4000_0014, 32'h4000_0018};
    logic [31:0] wr_data [3] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333};

    function automatic cfg_table_t build_table_a();
        cfg_table_t t;
        for (int i = 0; i < int'(CFG_TABLE_DEPTH); i++) t[i] = cfg_entry(OpEnd, '0, '0, '0);
        t[0] = cfg_entry(OpWrite, 32'h4000_0010, 32'h0000_1111, 32'h0);
        t[1] = cfg_entry(OpWrite, 32'h4000_0014, 32'h0000_2222, 32'h0);
        t[2] = cfg_entry(OpWrite, 32'h4000_0018, 32'h0000_3333, 32'h0);
        return t;
    endfunction

    function automatic cfg_table_t build_table_b();
        cfg_table_t t;
        for (int i = 0; i < int'(CFG_TABLE_DEPTH); i++) t[i] = cfg_entry(OpEnd, '0, '0, '0);
        t[0] = cfg_entry(OpPoll, 32'h4000_0004, 32'h0000_0001, 32'h0000_0001);
        t[1] = cfg_entry(OpWait, 32'h0, 32'h0000_0002, 32'h0);
        return t;
    endfunction

    localparam cfg_table_t TABLE_A = build_table_a();
    localparam cfg_table_t TABLE_B = build_table_b();

    // DUT A signals
    logic        a_start = 1'b0, a_busy, a_done, a_err;
    logic [1:0]  a_err_idx;
    logic [31:0] a_haddr, a_hwdata;
    logic        a_hwrite, a_hbusreq, a_hreadyin;
    logic [1:0]  a_htrans;
    logic [2:0]  a_hsize, a_hburst;
    logic        a_hready = 1'b1, a_hgrant = 1'b1;
    logic [31:0] a_hrdata = 32'h0;
    logic [1:0]  a_hresp = HRESP_OKAY;

    // DUT B signals
    logic        b_start = 1'b0, b_busy, b_done, b_err;
    logic [0:0]  b_err_idx;
    logic [31:0] b_haddr, b_hwdata;
    logic        b_hwrite, b_hbusreq, b_hreadyin;
    logic [1:0]  b_htrans;
    logic [2:0]  b_hsize, b_hburst;
    logic        b_hready = 1'b1, b_hgrant = 1'b1;
    logic [31:0] b_hrdata = 32'h0;
    logic [1:0]  b_hresp = HRESP_OKAY;

    mc_ahb_cfg_master #(
        .NUM_ENTRIES (4),
        .CFG_TABLE   (TABLE_A)
    ) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .i_start        (a_start),
        .o_busy         (a_busy),
        .o_done         (a_done),
        .o_err          (a_err),
        .o_err_idx      (a_err_idx),
        .o_ahb_haddr    (a_haddr),
        .o_ahb_hwrite   (a_hwrite),
        .o_ahb_hwdata   (a_hwdata),
        .o_ahb_htrans   (a_htrans),
        .o_ahb_hsize    (a_hsize),
        .o_ahb_hburst   (a_hburst),
        .o_ahb_hbusreq  (a_hbusreq),
        .o_ahb_hreadyin (a_hreadyin),
        .i_ahb_hready   (a_hready),
        .i_ahb_hrdata   (a_hrdata),
        .i_ahb_hresp    (a_hresp),
        .i_ahb_hgrant   (a_hgrant)
    );

    mc_ahb_cfg_master #(
        .NUM_ENTRIES  (2),
        .POLL_TIMEOUT (64),
        .CFG_TABLE    (TABLE_B)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .i_start        (b_start),
        .o_busy         (b_busy),
        .o_done         (b_done),
        .o_err          (b_err),
        .o_err_idx      (b_err_idx),
        .o_ahb_haddr    (b_haddr),
        .o_ahb_hwrite   (b_hwrite),
        .o_ahb_hwdata   (b_hwdata),
        .o_ahb_htrans   (b_htrans),
        .o_ahb_hsize    (b_hsize),
        .o_ahb_hburst   (b_hburst),
        .o_ahb_hbusreq  (b_hbusreq),
        .o_ahb_hreadyin (b_hreadyin),
        .i_ahb_hready   (b_hready),
        .i_ahb_hrdata   (b_hrdata),
        .i_ahb_hresp    (b_hresp),
        .i_ahb_hgrant   (b_hgrant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled at the end of cycle 0; returns in cycle 1.
    task automatic pulse_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic pulse_b();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_busy, a_done, a_err, a_hwrite, a_hbusreq} !== 5'b0 || a_err_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_status_a: got busy/done/err/hwrite/hbusreq=%b idx=%0d, want 00000 0",
                     {a_busy, a_done, a_err, a_hwrite, a_hbusreq}, a_err_idx);
        end
        checks++;
        if (a_haddr !== 32'h0 || a_hwdata !== 32'h0 || a_htrans !== 2'b00) begin
            errors++;
            $display("FAIL reset_bus_a: got haddr=%h hwdata=%h htrans=%b, want 0 0 00",
                     a_haddr, a_hwdata, a_htrans);
        end
        checks++;
        if (a_hsize !== 3'b010 || a_hburst !== 3'b000) begin
            errors++;
            $display("FAIL reset_size_burst: got hsize=%b hburst=%b, want 010 000", a_hsize, a_hburst);
        end
        checks++;
        if ({b_busy, b_done, b_err, b_hbusreq} !== 4'b0 || b_htrans !== 2'b00) begin
            errors++;
            $display("FAIL reset_b: got busy/done/err/hbusreq=%b htrans=%b, want 0000 00",
                     {b_busy, b_done, b_err, b_hbusreq}, b_htrans);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_writes();
        pulse_a();
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 3 || cyc == 7 || cyc == 11) begin
                checks++;
                if (a_htrans !== 2'b10 || a_haddr !== wr_addr[(cyc-3)/4] || a_hwrite !== 1'b1) begin
                    errors++;
                    $display("FAIL writes_addr c%0d: got htrans=%b haddr=%h hwrite=%b, want 10 %h 1",
                             cyc, a_htrans, a_haddr, a_hwrite, wr_addr[(cyc-3)/4]);
                end
            end else begin
                checks++;
                if (a_htrans !== 2'b00) begin
                    errors++;
                    $display("FAIL writes_idle c%0d: got htrans=%b, want 00", cyc, a_htrans);
                end
            end
            if (cyc == 4 || cyc == 8 || cyc == 12) begin
                checks++;
                if (a_hwdata !== wr_data[(cyc-4)/4] || a_hbusreq !== 1'b1) begin
                    errors++;
                    $display("FAIL writes_data c%0d: got hwdata=%h hbusreq=%b, want %h 1",
                             cyc, a_hwdata, a_hbusreq, wr_data[(cyc-4)/4]);
                end
            end
            if (cyc == 1) begin
                checks++;
                if (a_busy !== 1'b1 || a_hbusreq !== 1'b0) begin
                    errors++;
                    $display("FAIL writes_fetch: got busy=%b hbusreq=%b, want 1 0", a_busy, a_hbusreq);
                end
            end
            if (cyc == 13) begin
                checks++;
                if (a_done !== 1'b0 || a_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL writes_early_done: got done=%b busy=%b, want 0 1", a_done, a_busy);
                end
            end
            if (cyc == 14) begin
                checks++;
                if (a_done !== 1'b1 || a_busy !== 1'b0 || a_err !== 1'b0) begin
                    errors++;
                    $display("FAIL writes_done: got done=%b busy=%b err=%b, want 1 0 0",
                             a_done, a_busy, a_err);
                end
            end
            if (cyc < 14) tick();
        end
    endtask

    task automatic test_start_busy();
        pulse_a();
        repeat (4) tick();
        a_start = 1'b1;  // cycle 5, mid-sequence: must be ignored
        tick();
        a_start = 1'b0;
        repeat (7) tick();
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_c13: got done=%b busy=%b, want 0 1", a_done, a_busy);
        end
        tick();
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_c14: got done=%b, want 1", a_done);
        end
    endtask

    task automatic test_wait_states();
        pulse_a();
        tick();
        a_hready = 1'b0;
        for (int cyc = 3; cyc <= 5; cyc++) begin
            tick();
            if (cyc == 5) a_hready = 1'b1;
            checks++;
            if (a_htrans !== 2'b10 || a_haddr !== wr_addr[0] || a_hwrite !== 1'b1 ||
                a_hreadyin !== a_hready) begin
                errors++;
                $display("FAIL wait_addr c%0d: got htrans=%b haddr=%h hwrite=%b hreadyin=%b, want 10 %h 1 %b",
                         cyc, a_htrans, a_haddr, a_hwrite, a_hreadyin, wr_addr[0], a_hready);
            end
        end
        for (int cyc = 6; cyc <= 8; cyc++) begin
            tick();
            a_hready = (cyc == 8);
            checks++;
            if (a_htrans !== 2'b00 || a_hwdata !== wr_data[0] || a_hbusreq !== 1'b1) begin
                errors++;
                $display("FAIL wait_data c%0d: got htrans=%b hwdata=%h hbusreq=%b, want 00 %h 1",
                         cyc, a_htrans, a_hwdata, a_hbusreq, wr_data[0]);
            end
        end
        tick();
        checks++;
        if (a_hbusreq !== 1'b0 || a_htrans !== 2'b00 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_fetch c9: got hbusreq=%b htrans=%b busy=%b, want 0 00 1",
                     a_hbusreq, a_htrans, a_busy);
        end
        repeat (8) tick();
        checks++;
        if (a_done !== 1'b0) begin
            errors++;
            $display("FAIL wait_c17: got done=%b, want 0", a_done);
        end
        tick();
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_c18: got done=%b, want 1", a_done);
        end
    endtask

    task automatic test_error();
        pulse_a();
        repeat (11) tick();
        checks++;
        if (a_htrans !== 2'b00 || a_hwdata !== wr_data[2]) begin
            errors++;
            $display("FAIL error_dphase c12: got htrans=%b hwdata=%h, want 00 %h",
                     a_htrans, a_hwdata, wr_data[2]);
        end
        a_hresp = HRESP_ERROR;
        tick();
        a_hresp = HRESP_OKAY;
        checks++;
        if ({a_err, a_busy, a_done, a_hbusreq} !== 4'b1000 || a_err_idx !== 2'd2) begin
            errors++;
            $display("FAIL error_report: got err/busy/done/hbusreq=%b idx=%0d, want 1000 2",
                     {a_err, a_busy, a_done, a_hbusreq}, a_err_idx);
        end
        repeat (2) tick();
        checks++;
        if (a_err !== 1'b1 || a_err_idx !== 2'd2 || a_htrans !== 2'b00) begin
            errors++;
            $display("FAIL error_hold: got err=%b idx=%0d htrans=%b, want 1 2 00",
                     a_err, a_err_idx, a_htrans);
        end
        pulse_a();
        checks++;
        if (a_err !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL error_clear: got err=%b busy=%b, want 0 1", a_err, a_busy);
        end
        repeat (13) tick();
        checks++;
        if (a_done !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL error_rerun: got done=%b err=%b, want 1 0", a_done, a_err);
        end
    endtask

    task automatic test_grant_reset();
        a_hgrant = 1'b0;
        pulse_a();
        for (int cyc = 2; cyc <= 12; cyc++) begin
            tick();
            checks++;
            if (a_htrans !== 2'b00 || a_hbusreq !== 1'b1) begin
                errors++;
                $display("FAIL grant_wait c%0d: got htrans=%b hbusreq=%b, want 00 1",
                         cyc, a_htrans, a_hbusreq);
            end
            if (cyc == 12) a_hgrant = 1'b1;
        end
        tick();
        checks++;
        if (a_htrans !== 2'b10 || a_haddr !== wr_addr[0]) begin
            errors++;
            $display("FAIL grant_addr c13: got htrans=%b haddr=%h, want 10 %h",
                     a_htrans, a_haddr, wr_addr[0]);
        end
        tick();
        rst = 1'b1;  // asserted during the data phase
        tick();
        checks++;
        if ({a_busy, a_done, a_err, a_hwrite, a_hbusreq} !== 5'b0 || a_err_idx !== 2'd0 ||
            a_haddr !== 32'h0 || a_hwdata !== 32'h0 || a_htrans !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b idx=%0d haddr=%h hwdata=%h htrans=%b, want 00000 0 0 0 00",
                     {a_busy, a_done, a_err, a_hwrite, a_hbusreq}, a_err_idx, a_haddr, a_hwdata,
                     a_htrans);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_poll();
        int reads;
        reads    = 0;
        b_hrdata = 32'hFFFF_FFFE;
        pulse_b();
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (b_htrans === 2'b10) begin
                reads++;
                checks++;
                if (b_hwrite !== 1'b0 || b_haddr !== 32'h4000_0004) begin
                    errors++;
                    $display("FAIL poll_read c%0d: got hwrite=%b haddr=%h, want 0 40000004",
                             cyc, b_hwrite, b_haddr);
                end
                b_hrdata = (reads >= 4) ? 32'h0000_0003 : 32'hFFFF_FFFE;
            end
            if (cyc == 12) begin
                checks++;
                if (b_hbusreq !== 1'b0 || b_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL poll_delay c12: got hbusreq=%b busy=%b, want 0 1", b_hbusreq, b_busy);
                end
            end
            if (cyc == 14) begin
                checks++;
                if (b_done !== 1'b0 || b_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL poll_c14: got done=%b busy=%b, want 0 1", b_done, b_busy);
                end
            end
            if (cyc == 15) begin
                checks++;
                if (b_done !== 1'b1 || b_err !== 1'b0) begin
                    errors++;
                    $display("FAIL poll_done c15: got done=%b err=%b, want 1 0", b_done, b_err);
                end
            end
            if (cyc < 15) tick();
        end
        checks++;
        if (reads !== 4) begin
            errors++;
            $display("FAIL poll_reads: got %0d reads, want 4", reads);
        end
    endtask

`ifdef MC_CFG_POLL_TIMEOUT_EN
    task automatic test_timeout();
        int first_err;
        first_err = 0;
        b_hrdata  = 32'h0;
        pulse_b();
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (b_err === 1'b1 && first_err == 0) first_err = cyc;
            tick();
        end
        checks++;
        if (first_err < 64 || first_err > 68) begin
            errors++;
            $display("FAIL timeout_cycle: got err at cycle %0d (0=never), want 64..68", first_err);
        end
        checks++;
        if (b_err !== 1'b1 || b_err_idx !== 1'b0 || b_hbusreq !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got err=%b idx=%0d hbusreq=%b, want 1 0 0",
                     b_err, b_err_idx, b_hbusreq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_writes();
        test_start_busy();
        test_wait_states();
        test_error();
        test_grant_reset();
        test_poll();
`ifdef MC_CFG_POLL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ahb_cfg_master.md
# mc_ahb_cfg_master

AHB master that programs the memory-controller CSR block after reset. It walks a table of configuration entries held in a small ROM and issues single AHB transfers: register writes, read-polls until a field matches, and fixed delays. It then reports completion or error to system control. It sits on the AHB clock domain and drives the AHB bus that the CSR slave responds to.

## Interface
- `NUM_ENTRIES`, default 32: number of table entries; the entry index is `$clog2(NUM_ENTRIES)` bits wide.
- `POLL_TIMEOUT`, default 4096: cycles allowed per POLL entry (used only with `MC_CFG_POLL_TIMEOUT_EN`).

Ports:
- `clk`  in  1  AHB clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  single-cycle pulse; starts the sequence from entry 0 (accepted only in IDLE, DONE or ERR).
- `o_busy`  out  1  sequence in progress.
- `o_done`  out  1  sequence completed; held until the next accepted `i_start`.
- `o_err`  out  1  AHB ERROR response or poll timeout; held until the next accepted `i_start`.
- `o_err_idx`  out  `$clog2(NUM_ENTRIES)`  index of the failing entry.
- `o_ahb_haddr`  out  32  address.
- `o_ahb_hwrite`  out  1  write/read.
- `o_ahb_hwdata`  out  32  write data.
- `o_ahb_htrans`  out  2  IDLE=2'b00, NONSEQ=2'b10.
- `o_ahb_hsize`  out  3  constant 3'b010 (word).
- `o_ahb_hburst`  out  3  constant 3'b000 (SINGLE).
- `o_ahb_hbusreq`  out  1  bus request.
- `o_ahb_hreadyin`  out  1  equals `i_ahb_hready`.
- `i_ahb_hready`  in  1  slave ready.
- `i_ahb_hrdata`  in  32  read data.
- `i_ahb_hresp`  in  2  OKAY=2'b00, ERROR=2'b01.
- `i_ahb_hgrant`  in  1  bus grant.

## Operation
- Each entry holds `op[1:0]`, `addr[31:0]`, `data[31:0]` and `mask[31:0]`.
  - WRITE=0, POLL=1, WAIT=2, END=3.
- FSM states: IDLE, FETCH, GRANT, ADDR, DATA, DELAY, DONE, ERR.
- **IDLE/DONE/ERR + `i_start`:** index←0; clear `o_done` and `o_err`; go to FETCH.
- **FETCH:** the ROM read is registered, so entry data is valid in FETCH. Decode the op:
  - WRITE or POLL → GRANT.
  - WAIT → DELAY; counter←`data[15:0]`.
  - END → DONE.
- **GRANT:** `o_ahb_hbusreq`=1. When `i_ahb_hgrant`=1 is sampled, go to ADDR.
- **ADDR:**
  - Drive `htrans`=NONSEQ, `haddr`=`addr`, and `hwrite`=1 for WRITE / 0 for POLL.
  - Hold all of these until `i_ahb_hready`=1, then go to DATA.
- **DATA:**
  - Drive `htrans`=IDLE; `hwdata`=`data` for WRITE.
  - On `i_ahb_hready`=1:
    - If `hresp`≠OKAY → ERR and latch `o_err_idx`.
    - WRITE → index+1, go to FETCH.
    - POLL with `(hrdata & mask)==(data & mask)` → index+1, go to FETCH.
    - POLL with no match → ADDR (re-issue the read; `hbusreq` stays high).
- **DELAY:** counter decrements each cycle; at 0, index+1 and go to FETCH. A count of 0 spends exactly one cycle in DELAY.
- **Index wrap:** if the index would reach `NUM_ENTRIES` without an END entry → DONE.
- **`hbusreq`:** asserted in GRANT, ADDR and DATA; deasserted in all other states.
- **`i_start` while busy:** ignored.

## Timing
- Reset values: state IDLE, index 0, `o_busy`/`o_done`/`o_err`=0, `o_err_idx`=0, `haddr`/`hwdata`=0, `htrans`=IDLE, `hwrite`=0, `hbusreq`=0.
- `o_busy`=1 in every state except IDLE, DONE and ERR.
- WRITE with immediate grant and zero wait states: `i_start` at cycle 0 → FETCH cycle 1, GRANT cycle 2, NONSEQ on bus at cycle 3, data phase at cycle 4, next FETCH at cycle 5.
- Each subsequent WRITE costs 4 cycles plus slave wait states.
- Transfers are never pipelined: the address phase of the next transfer never overlaps the current data phase.
- `rst` asserted mid-transfer returns to IDLE on the next edge, with all outputs at their reset values.

## Configuration
- **`MC_CFG_POLL_TIMEOUT_EN` defined:**
  - A 16-bit poll counter clears on entry to each POLL and increments every cycle spent in ADDR or DATA for that entry.
  - At `POLL_TIMEOUT`: go to ERR with `o_err_idx` latched. Any transfer in progress completes its data phase first; its result is discarded.
- **Undefined:** POLL retries forever and no counter exists.

## Structure
- Package `mc_cfg_pkg`:
  - op enum;
  - entry struct;
  - HTRANS/HRESP/HSIZE/HBURST constants;
  - default CSR address constants.
- Sub-module `mc_cfg_rom`: registered ROM indexed by entry index, initialised from package constants. The default table:
  - writes the CSR timing fields;
  - sets the init-request bit;
  - polls `initialize_done`;
  - ends.

## Test plan
- Three WRITE entries then END, slave always ready and granted → three NONSEQ writes with the table addr/data, `o_done`=1 at cycle 14.
- Slave inserts 2 wait states in both the address and data phases of a WRITE → address and data held stable, and the FSM advances only on `hready`=1.
- POLL with `mask`=1, `data`=1; slave returns 0 three times then 1 → 4 reads issued, then `o_done`=1.
- `hresp`=ERROR on entry 2 → `o_err`=1, `o_err_idx`=2, `hbusreq`=0, `o_busy`=0.
- With `MC_CFG_POLL_TIMEOUT_EN` and `POLL_TIMEOUT`=64, slave never matches → `o_err`=1 within 64+4 cycles.
- `hgrant` withheld for 10 cycles, then `rst` pulsed mid-DATA → no NONSEQ before the grant; after `rst`, all outputs are at reset values and `o_busy`=0.
